// File: rtl/cla_arbiter_pkg.sv
// cla_arbiter_pkg: shared types, constants and arbitration helper for the CLA arbiter
package cla_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Returns the winning requester index; only meaningful when at least one is valid
    function automatic logic pick_winner(input logic rr_en, input logic v0, input logic v1,
                                         input logic last_grant);
        return rr_en ? ((v0 & v1) ? ~last_grant : v1) : ~v0;
    endfunction

endpackage

// File: rtl/cla_arbiter_cla8.sv
// CLA8Bit: 8-bit carry-lookahead adder/subtractor, subtract is A + ~B + 1
module CLA8Bit
    import cla_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              op,
    output logic [DATA_W-1:0] S,
    output logic              cout
);

    logic [DATA_W-1:0] bx;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W:0]   c;
    logic              prod;

    // Each carry is a flat sum of generate terms gated by the propagates above them
    always_comb begin
        bx   = (op == OP_SUB) ? ~B : B;
        g    = A & bx;
        p    = A ^ bx;
        c    = '0;
        prod = 1'b1;
        c[0] = op;
        for (int i = 0; i < DATA_W; i++) begin
            prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (prod & g[j]);
                prod   = prod & p[j];
            end
            c[i+1] = c[i+1] | (prod & op);
        end
        S    = p ^ c[DATA_W-1:0];
        cout = c[DATA_W];
    end

endmodule

// File: rtl/cla_arbiter.sv
// cla_arbiter: two requesters share one CLA8Bit adder with a one-deep result register
module cla_arbiter
    import cla_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_sum,
    output logic              rsp_cout
);

    state_e            state_q;
    state_e            state_d;
    logic              last_grant_q;
    logic              id_q;
    logic [DATA_W-1:0] sum_q;
    logic              cout_q;
    logic              win;
    logic              accept_ok;
    logic              accept;
    logic [DATA_W-1:0] a_mux;
    logic [DATA_W-1:0] b_mux;
    logic              op_mux;
    logic [DATA_W-1:0] s;
    logic              co;

    // Arbitration and operand steering; nothing is accepted while reset is held
    always_comb begin
        win       = pick_winner(RR_EN, req0_valid, req1_valid, last_grant_q);
        accept_ok = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & rsp_ready));
        accept    = accept_ok & (req0_valid | req1_valid);
        a_mux     = win ? req1_a : req0_a;
        b_mux     = win ? req1_b : req0_b;
        op_mux    = win ? req1_op : req0_op;
    end

    CLA8Bit u_cla (
        .A    (a_mux),
        .B    (b_mux),
        .op   (op_mux),
        .S    (s),
        .cout (co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a new accept always lands in HOLD, a drained result with no accept returns to IDLE
    always_comb begin
        state_d = accept ? HOLD : ((state_q == HOLD) & rsp_ready) ? IDLE : state_q;
    end

    // Outputs: grants follow the winner, response fields come straight from the result register
    always_comb begin
        req0_ready = accept & ~win;
        req1_ready = accept & win;
        rsp_valid  = (state_q == HOLD);
        rsp_id     = id_q;
        rsp_sum    = sum_q;
        rsp_cout   = cout_q;
    end

    // Result register and round-robin pointer, loaded only on an accepted transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q        <= '0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            sum_q        <= s;
            cout_q       <= co;
            id_q         <= win;
            last_grant_q <= win;
        end
    end

endmodule

// File: tb/tb_cla_arbiter.sv
// tb_cla_arbiter: table-driven directed checks of arbitration, handshake, hold and reset
module tb_cla_arbiter;
    import cla_arbiter_pkg::*;

    typedef struct packed {
        logic       v0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic       o0;
        logic       v1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       o1;
        logic       rr;
        logic       r0;
        logic       r1;
        logic       vld;
        logic       dc;
        logic       id;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, req0_op, req1_op, rsp_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout;
    logic [7:0] rsp_sum;
    logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_cout;
    logic [7:0] fp_rsp_sum;
    int         passed = 0;
    int         total = 0;
    vec_t       tbl[15];

    always #5 clk = ~clk;

    cla_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
    );

    cla_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_sum(fp_rsp_sum), .rsp_cout(fp_rsp_cout)
    );

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.o0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.o1;
        rsp_ready  = v.rr;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h04, 8'h03, OP_ADD, 1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 8'h0D, 8'h0A, OP_SUB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 8'h03, 8'h04, OP_SUB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0};
        tbl[3]  = '{1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1, 8'h10, 8'h20, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[4]  = '{1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1, 8'h10, 8'h20, OP_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h30, 1'b0};
        tbl[5]  = '{1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1, 8'h10, 8'h20, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1, 8'h10, 8'h20, OP_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h30, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, OP_ADD, 1'b0, 8'h00, 8'h00, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 8'h0F, 8'h0A, OP_ADD, 1'b0, 8'h00, 8'h00, OP_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h19, 1'b0};
        for (int i = 9; i < 14; i++)
            tbl[i] = '{1'b1, 8'h01, 8'h01, OP_ADD, 1'b1, 8'h02, 8'h02, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h19, 1'b0};
        tbl[14] = '{1'b1, 8'h01, 8'h01, OP_ADD, 1'b1, 8'h02, 8'h02, OP_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0};

        rst_n = 1'b0;
        drive(tbl[3]);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready0", {8'h0, req0_ready}, 9'h0);
        chk("rst_ready1", {8'h0, req1_ready}, 9'h0);
        chk("rst_valid", {8'h0, rsp_valid}, 9'h0);
        chk("rst_sum", {1'b0, rsp_sum}, 9'h0);
        chk("rst_cout_id", {7'h0, rsp_cout, rsp_id}, 9'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i]);
            #4;
            chk($sformatf("v%0d_ready", i), {7'h0, req0_ready, req1_ready}, {7'h0, tbl[i].r0, tbl[i].r1});
            chk($sformatf("v%0d_fp_ready", i), {7'h0, fp_req0_ready, fp_req1_ready},
                {7'h0, (tbl[i].r0 | tbl[i].r1) & tbl[i].v0, (tbl[i].r0 | tbl[i].r1) & ~tbl[i].v0});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {8'h0, rsp_valid}, {8'h0, tbl[i].vld});
            if (tbl[i].dc) begin
                chk($sformatf("v%0d_sum", i), {1'b0, rsp_sum}, {1'b0, tbl[i].sum});
                chk($sformatf("v%0d_cout_id", i), {7'h0, rsp_cout, rsp_id}, {7'h0, tbl[i].cout, tbl[i].id});
            end
        end

        rst_n = 1'b0;
        drive(tbl[9]);
        #4;
        chk("hold_rst_ready", {7'h0, req0_ready, req1_ready}, 9'h0);
        chk("hold_rst_fp_ready", {7'h0, fp_req0_ready, fp_req1_ready}, 9'h0);
        @(posedge clk);
        #1;
        chk("hold_rst_valid", {8'h0, rsp_valid}, 9'h0);
        chk("hold_rst_sum", {1'b0, rsp_sum}, 9'h0);
        chk("hold_rst_cout_id", {7'h0, rsp_cout, rsp_id}, 9'h0);

        rst_n = 1'b1;
        drive(tbl[7]);
        @(posedge clk);
        #1;
        chk("idle_rsp_ready_ignored", {8'h0, rsp_valid}, 9'h0);

        drive('{1'b1, 8'h05, 8'h06, OP_ADD, 1'b1, 8'h07, 8'h08, OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
        #4;
        chk("tie_after_rst_ready", {7'h0, req0_ready, req1_ready}, 9'h2);
        @(posedge clk);
        #1;
        chk("tie_after_rst_sum", {1'b0, rsp_sum}, 9'h0B);
        chk("tie_after_rst_id", {8'h0, rsp_id}, 9'h0);

        rsp_ready = 1'b1;
        #4;
        chk("second_tie_ready", {7'h0, req0_ready, req1_ready}, 9'h1);
        @(posedge clk);
        #1;
        chk("second_tie_sum", {1'b0, rsp_sum}, 9'h0F);
        chk("second_tie_id", {8'h0, rsp_id}, 9'h1);
        chk("fp_second_id", {8'h0, fp_rsp_id}, 9'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cla_arbiter.md
CLA_ARBITER -- requirements
Module: cla_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  8 each  requester 0 operands
- req0_op  in  1  requester 0 op; 0 = add, 1 = subtract (A-B)
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer takes result this cycle
- rsp_id  out  1  requester that issued the held result
- rsp_sum  out  8  result S
- rsp_cout  out  1  adder carry out

Function
REQ-003 The block SHALL share one CLA8Bit adder between two requesters; one operation in flight at a time.
REQ-004 Handshake: transfer on valid&ready per port; valid SHALL NOT depend on ready; payload sampled only on transfer.
REQ-005 accept_ok = (state==IDLE) | (state==HOLD & rsp_ready); at most one reqN_ready high per cycle, and only when accept_ok and that requester wins arbitration.
REQ-006 Arbitration, RR_EN=1: only one valid -> it wins; both valid -> requester != last_grant wins; last_grant updates only on an accepted transfer.
REQ-007 Arbitration, RR_EN=0: requester 0 wins whenever req0_valid=1.
REQ-008 On accepted operation in cycle N, CLA8Bit computes combinationally from the winner's operands; sum, cout, id registered at edge ending N; rsp_valid=1 from cycle N+1 (latency 1).
REQ-009 Arithmetic: op=0 -> {cout,S}=A+B; op=1 -> {cout,S}=A+~B+1, modulo 256; cout=1 for subtract means no borrow.
REQ-010 States: IDLE (rsp_valid=0), HOLD (rsp_valid=1). IDLE->HOLD on accept; HOLD->IDLE on rsp_ready with no accept; HOLD->HOLD on rsp_ready with accept (back-to-back, new result replaces old); HOLD stays with outputs stable while rsp_ready=0.
REQ-011 rsp_sum/rsp_cout/rsp_id SHALL remain constant throughout HOLD until rsp_ready transfer.
REQ-012 rsp_ready while IDLE SHALL be ignored.
REQ-013 Sustained throughput: one operation per cycle when rsp_ready held 1.

Reset
REQ-014 While rst_n=0 at a clock edge: state=IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, last_grant=1 (requester 0 wins first tie).
REQ-015 reqN_ready SHALL be 0 during any cycle rst_n=0; an operation held in HOLD when reset asserts SHALL be discarded without rsp transfer.

Structure
REQ-016 Shared package: state encoding (IDLE=0, HOLD=1), OP_ADD=0, OP_SUB=1, DATA_W=8.
REQ-017 Exactly one sub-module instance: CLA8Bit (ports A, B, op, S, cout), unmodified; arbitration, FSM, result register live in cla_arbiter.

Verification
REQ-018 Bench SHALL cover:
- req0 only, A=8'h04 B=8'h03 op=0 -> next cycle rsp_valid=1, sum=8'h07, cout=0, id=0
- req1 only, A=8'h0D B=8'h0A op=1 -> sum=8'h03, cout=1, id=1; then A=8'h03 B=8'h04 op=1 -> sum=8'hFF, cout=0
- both valid every cycle, RR_EN=1, rsp_ready=1 -> grants 0,1,0,1; A=8'hFF B=8'h01 op=0 on req0 -> sum=8'h00, cout=1
- rsp_ready=0 for 5 cycles with result 8'h19 (8'h0F+8'h0A) held -> outputs stable, both reqN_ready=0, rsp_ready=1 with pending req -> new result next cycle
- rst_n=0 during HOLD -> next cycle rsp_valid=0, rsp_sum=0; first tie after reset granted to requester 0
